// File: rtl/iiitb_cg_ctrl.sv
// Activity-driven clock-gating controller: one RUN/OFF/WAKE FSM per gated domain,
// each driving the enable of its ICG cell from the ungated clk domain.
module iiitb_cg_ctrl #(
  parameter int NCH      = 4,
  parameter int IDLE_CYC = 8,
  parameter int WAKE_CYC = 2,
  parameter int CW       = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] act,
  input  logic [NCH-1:0] force_on,
  output logic [NCH-1:0] cg_en,
  output logic [NCH-1:0] rdy,
  output logic [NCH-1:0] off_mask,
  output logic           all_off
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    OFF  = 2'd1,
    WAKE = 2'd2
  } state_t;

  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYC - 1);
  localparam logic [CW-1:0] WAKE_LAST = CW'((WAKE_CYC > 0) ? (WAKE_CYC - 1) : 0);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;
    logic            busy;

    assign busy = act[i] | force_on[i];

    // Reset lands in RUN so every domain keeps its clock while its own reset propagates.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= RUN;
        cnt   <= '0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
      end
    end

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
        RUN: begin
          if (busy) begin
            cnt_nx = '0;
          end else if (cnt == IDLE_LAST) begin
            state_nx = OFF;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        OFF: begin
          if (busy) begin
            state_nx = (WAKE_CYC > 0) ? WAKE : RUN;
            cnt_nx   = '0;
          end
        end
        // Once started, a wake always runs to completion regardless of act.
        WAKE: begin
          if (cnt == WAKE_LAST) begin
            state_nx = RUN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      endcase
    end

    assign cg_en[i]    = (state != OFF);
    assign rdy[i]      = (state == RUN);
    assign off_mask[i] = (state == OFF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) all_off <= 1'b0;
    else        all_off <= &off_mask;
  end

endmodule
